// File: rtl/sb_io_uart_rx.sv
// sb_io_uart_rx: 8N1 UART receiver fed by an SB_IO input pin (D_IN_0).
// The raw pin is double-flopped, each frame is sampled at mid-bit, and every received byte is
// handed to fabric logic over a valid/ready handshake. Framing and overrun errors are reported
// as one-cycle pulses.
//
// Optional feature: define UART_RX_PARITY_EN to insert one even-parity bit between the data
// bits and the stop bit and to add the PERR output.
//
// Ports:
//   C      in   clock, all state changes on the rising edge
//   R      in   asynchronous active-low reset
//   D_IN   in   serial line from SB_IO D_IN_0, idle high
//   DATA   out  received byte, LSB first on the wire
//   VALID  out  DATA holds an unconsumed byte
//   READY  in   consumer takes DATA when VALID && READY
//   FERR   out  one-cycle pulse, stop bit sampled low
//   OVR    out  one-cycle pulse, byte completed while the previous one was still held
//   PERR   out  parity error belonging to DATA (UART_RX_PARITY_EN only)
module sb_io_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       C,
  input  logic       R,
  input  logic       D_IN,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       FERR,
  output logic       OVR
`ifdef UART_RX_PARITY_EN
  ,
  output logic       PERR
`endif
);

  localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  logic            sync_q, rxs_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            brk_q, brk_d;    // line seen low at a stop bit; wait for high before re-arming
  logic            done_q, done_d;  // good frame finished, deliver on the next edge
  logic            ferr_q, ferr_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic            parity_q, parity_d;
  logic            perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntOne;
    idx_d   = idx_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_d = parity_q;
`endif
    if (rxs_q) brk_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs_q && !brk_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (rxs_q) begin
            state_d = StIdle;  // glitch, dropped silently
          end else begin
            state_d = StData;
            idx_d   = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs_q;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntFull) begin
          cnt_d    = '0;
          parity_d = rxs_q;
          state_d  = StStop;
        end
      end
`endif
      StStop: begin
        // Back to idle at the mid-sample so a start edge in the late stop half is caught.
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rxs_q) begin
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output handshake; a completion in the same cycle as a consume keeps VALID high.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (valid_q && READY) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || READY) begin
        data_d  = shift_q;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        perr_d  = (^shift_q) ^ parity_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      brk_q   <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= D_IN;
      rxs_q   <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      brk_q   <= brk_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      parity_q <= parity_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign DATA  = data_q;
  assign VALID = valid_q;
  assign FERR  = ferr_q;
  assign OVR   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign PERR  = perr_q;
`endif

endmodule

// File: tb/tb_sb_io_uart_rx.sv
`timescale 1ns/1ps
module tb_sb_io_uart_rx;

  localparam int unsigned Cpb = 16;

  logic       C = 1'b0;
  logic       R;
  logic       D_IN;
  logic       READY;
  logic [7:0] DATA;
  logic       VALID;
  logic       FERR;
  logic       OVR;
`ifdef UART_RX_PARITY_EN
  logic       PERR;
`endif

  sb_io_uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .C     (C),
    .R     (R),
    .D_IN  (D_IN),
    .DATA  (DATA),
    .VALID (VALID),
    .READY (READY),
    .FERR  (FERR),
    .OVR   (OVR)
`ifdef UART_RX_PARITY_EN
    ,
    .PERR  (PERR)
`endif
  );

  always #5 C = ~C;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  // Monitor event counters (cycles observed high, handshakes taken).
  int   accept_cnt = 0;
  int   valid_cyc  = 0;
  int   ferr_cyc   = 0;
  int   ovr_cyc    = 0;
  int   valid_rise = -1;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge C) cyc <= cyc + 1;

  // Scoreboard: every handshake pops the next expected byte.
  always @(negedge C) begin
    if (!R) begin
      prev_valid = 1'b0;
    end else begin
      if (VALID && !prev_valid) valid_rise = cyc;
      if (VALID) valid_cyc++;
      if (FERR) ferr_cyc++;
      if (OVR) ovr_cyc++;
      if (VALID && READY) begin
        accept_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", DATA);
        end else begin
          check("sb_data", DATA, exp_q.pop_front());
        end
      end
      prev_valid = VALID;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge C);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    D_IN = b;
    tick(Cpb);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_en,
                            input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par_en) send_bit(par);
    send_bit(stop);
    D_IN = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_acc;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int   a0, v0, f0, o0, start_cyc, lat;

  initial begin
    vecs[0] = '{data: 8'h3C, stop: 1'b1, exp_acc: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'hA3, stop: 1'b0, exp_acc: 0, exp_ferr: 1};
    vecs[2] = '{data: 8'h00, stop: 1'b1, exp_acc: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_acc: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'h80, stop: 1'b1, exp_acc: 1, exp_ferr: 0};
    vecs[5] = '{data: 8'h01, stop: 1'b1, exp_acc: 1, exp_ferr: 0};

    R = 1'b0;
    D_IN = 1'b1;
    READY = 1'b1;
    tick(3);
    check("rst_data", DATA, 8'h00);
    check("rst_valid", VALID, 1'b0);
    check("rst_ferr", FERR, 1'b0);
    check("rst_ovr", OVR, 1'b0);
    R = 1'b1;
    tick(5);

    // Frame 0x55 with latency measurement from the first edge that sees the start bit.
    a0 = accept_cnt; v0 = valid_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
    valid_rise = -1;
    start_cyc = cyc + 1;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("t1_accept", accept_cnt - a0, 1);
    check("t1_valid_cycles", valid_cyc - v0, 1);
    check("t1_ferr", ferr_cyc - f0, 0);
    check("t1_ovr", ovr_cyc - o0, 0);
    lat = valid_rise - start_cyc;
    checks++;
    if (lat < 154 || lat > 156) begin
      errors++;
      $display("FAIL t1_latency: got %0d cycles expected 155 +/-1", lat);
    end

    // Short low glitch: no output of any kind.
    a0 = accept_cnt; f0 = ferr_cyc; v0 = valid_cyc;
    D_IN = 1'b0;
    tick(5);
    D_IN = 1'b1;
    tick(40);
    check("t2_glitch_valid", valid_cyc - v0, 0);
    check("t2_glitch_ferr", ferr_cyc - f0, 0);

    // Table: back-to-back frames including a bad stop bit, READY held high.
    for (int i = 0; i < 6; i++) begin
      a0 = accept_cnt; f0 = ferr_cyc; o0 = ovr_cyc;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
      tick(4);
      check($sformatf("vec%0d_accept", i), accept_cnt - a0, vecs[i].exp_acc);
      check($sformatf("vec%0d_ferr", i), ferr_cyc - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), ovr_cyc - o0, 0);
    end

    // Overrun: second byte dropped while the first is still held.
    READY = 1'b0;
    a0 = accept_cnt; o0 = ovr_cyc;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("t4_valid_held", VALID, 1'b1);
    check("t4_data_first", DATA, 8'h12);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("t4_ovr_pulse", ovr_cyc - o0, 1);
    check("t4_data_kept", DATA, 8'h12);
    check("t4_valid_kept", VALID, 1'b1);
    READY = 1'b1;
    tick(1);
    check("t4_valid_cleared", VALID, 1'b0);
    check("t4_accept", accept_cnt - a0, 1);

    // Reset mid-frame while a byte is held.
    READY = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("t5_pre_data", DATA, 8'h5A);
    check("t5_pre_valid", VALID, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tick(8);
    R = 1'b0;
    #1;
    check("t5_rst_data", DATA, 8'h00);
    check("t5_rst_valid", VALID, 1'b0);
    check("t5_rst_ferr", FERR, 1'b0);
    check("t5_rst_ovr", OVR, 1'b0);
    tick(3);
    R = 1'b1;
    READY = 1'b1;
    tick(3);
    a0 = accept_cnt; f0 = ferr_cyc;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("t5_accept", accept_cnt - a0, 1);
    check("t5_no_ferr", ferr_cyc - f0, 0);

    // Line stuck low: exactly one framing error, then normal reception after release.
    a0 = accept_cnt; f0 = ferr_cyc;
    D_IN = 1'b0;
    tick(Cpb * 25);
    check("t7_break_ferr", ferr_cyc - f0, 1);
    check("t7_break_accept", accept_cnt - a0, 0);
    D_IN = 1'b1;
    tick(20);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    tick(4);
    check("t7_accept", accept_cnt - a0, 1);

`ifdef UART_RX_PARITY_EN
    READY = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    tick(4);
    check("t6_valid_bad", VALID, 1'b1);
    check("t6_data_bad", DATA, 8'h07);
    check("t6_perr_bad", PERR, 1'b1);
    READY = 1'b1;
    tick(1);
    READY = 1'b0;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    tick(4);
    check("t6_valid_good", VALID, 1'b1);
    check("t6_perr_good", PERR, 1'b0);
    READY = 1'b1;
    tick(1);
`endif

    tick(5);
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
